// File: rtl/matrix_pkg.sv
// matrix_pkg: shared matrix geometry, pixel mapping and scan states
package matrix_pkg;
    localparam int ROW = 4;
    localparam int COL = 4;
    localparam int PIXEL = ROW * COL;
    localparam int BIT_COUNT = 2;
    localparam int KEY_BITS = 4;
    typedef enum logic {DRIVE, EVAL} state_t;
    function automatic int pixel_index(input int r, input int c);
        return r * COL + c;
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: frame-level debounce of the key image with change events
module key_debounce #(
    parameter int PIXEL    = matrix_pkg::PIXEL,
    parameter int KEY_BITS = matrix_pkg::KEY_BITS,
    parameter int DEBOUNCE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PIXEL-1:0]    frame,
    input  logic                eval,
    output logic [PIXEL-1:0]    key_matrix,
    output logic                key_event,
    output logic [KEY_BITS-1:0] key_code,
    output logic                key_pressed
);
    import matrix_pkg::*;
    localparam int SW = $clog2(DEBOUNCE);
    localparam logic [SW-1:0] MAX = SW'(DEBOUNCE - 1);
    logic [PIXEL-1:0] prev_frame, rise, fall;
    logic [SW-1:0] stable, stable_n;
    logic [KEY_BITS-1:0] rise_code, fall_code;
    logic accept;
    // saturating stability count, change masks and lowest changed index
    always_comb begin
        stable_n = (frame != prev_frame) ? '0 : (stable == MAX) ? MAX : stable + 1'b1;
        rise = frame & ~key_matrix;
        fall = ~frame & key_matrix;
        accept = eval && stable_n == MAX && frame != key_matrix;
        rise_code = '0;
        fall_code = '0;
        for (int i = PIXEL - 1; i >= 0; i--) begin
            if (rise[i]) rise_code = KEY_BITS'(i);
            if (fall[i]) fall_code = KEY_BITS'(i);
        end
    end
    // history update on each eval strobe; accepted image and event report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_frame  <= '0;
            stable      <= '0;
            key_matrix  <= '0;
            key_event   <= 1'b0;
            key_code    <= '0;
            key_pressed <= 1'b0;
        end else begin
            key_event <= accept;
            if (eval) begin
                prev_frame <= frame;
                stable     <= stable_n;
            end
            if (accept) begin
                key_matrix  <= frame;
                key_code    <= |rise ? rise_code : fall_code;
                key_pressed <= |rise;
            end
        end
    end
endmodule

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: row-scanning keypad reader producing a debounced key image
module key_matrix_scan #(
    parameter int ROW           = matrix_pkg::ROW,
    parameter int COL           = matrix_pkg::COL,
    parameter int PIXEL         = ROW * COL,
    parameter int BIT_COUNT     = matrix_pkg::BIT_COUNT,
    parameter int KEY_BITS      = matrix_pkg::KEY_BITS,
    parameter int SETTLE_CYCLES = 16,
    parameter int DEBOUNCE      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [COL-1:0]       col_in,
    output logic [ROW-1:0]       row_out,
    output logic [BIT_COUNT-1:0] count,
    output logic [PIXEL-1:0]     key_matrix,
    output logic                 key_event,
    output logic [KEY_BITS-1:0]  key_code,
    output logic                 key_pressed
);
    import matrix_pkg::*;
    localparam int DW = $clog2(SETTLE_CYCLES);
    state_t state, state_n;
    logic [BIT_COUNT-1:0] count_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [COL-1:0] sync1, sync2;
    logic [PIXEL-1:0] frame, frame_n;
    logic [ROW-1:0] row_n;
    // two-flop synchronizer for the asynchronous column returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= col_in;
            sync2 <= sync1;
        end
    end
    // scan state, registered row drive and frame capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DRIVE;
            count   <= '0;
            dwell   <= '0;
            frame   <= '0;
            row_out <= '1;
        end else begin
            state   <= state_n;
            count   <= count_n;
            dwell   <= dwell_n;
            frame   <= frame_n;
            row_out <= row_n;
        end
    end
    // dwell timing, row stepping, column capture and the one-cycle eval slot
    always_comb begin
        state_n = state;
        count_n = count;
        dwell_n = dwell;
        frame_n = frame;
        if (state == EVAL) begin
            state_n = DRIVE;
        end else if (dwell == DW'(SETTLE_CYCLES - 1)) begin
            frame_n[count*COL +: COL] = ~sync2;
            dwell_n = '0;
            count_n = (count == BIT_COUNT'(ROW - 1)) ? '0 : count + 1'b1;
            state_n = (count == BIT_COUNT'(ROW - 1)) ? EVAL : DRIVE;
        end else begin
            dwell_n = dwell + 1'b1;
        end
        row_n = (state_n == DRIVE) ? ~(ROW'(1) << count_n) : '1;
    end
    key_debounce #(
        .PIXEL(PIXEL),
        .KEY_BITS(KEY_BITS),
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clk(clk),
        .rst_n(rst_n),
        .frame(frame),
        .eval(state == EVAL),
        .key_matrix(key_matrix),
        .key_event(key_event),
        .key_code(key_code),
        .key_pressed(key_pressed)
    );
endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: frame-level table, corner sequences and random checks
module tb_key_matrix_scan;
    localparam int DEB = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] col_in, row_out, key_code;
    logic [1:0] count;
    logic [15:0] key_matrix;
    logic key_event, key_pressed;
    logic [15:0] held = 16'h0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] mask;
        logic [15:0] km;
        logic        ev;
        logic [3:0]  code;
        logic        pr;
    } vec_t;
    vec_t vecs[$];

    logic [15:0] m_prev, m_km;
    int m_stable;
    logic m_ev, m_pr;
    logic [3:0] m_code;

    key_matrix_scan dut (
        .clk(clk),
        .rst_n(rst_n),
        .col_in(col_in),
        .row_out(row_out),
        .count(count),
        .key_matrix(key_matrix),
        .key_event(key_event),
        .key_code(key_code),
        .key_pressed(key_pressed)
    );

    always #5 clk = ~clk;

    // keypad model: a held key pulls its column low while its row is driven
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row_out[r]) col_in = col_in & ~held[r*4 +: 4];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset;
        m_prev = 16'h0;
        m_km = 16'h0;
        m_stable = 0;
        m_ev = 1'b0;
        m_pr = 1'b0;
        m_code = 4'h0;
    endtask

    task automatic model_eval(input logic [15:0] f);
        logic [15:0] rise, fall;
        m_stable = (f == m_prev) ? ((m_stable < DEB - 1) ? m_stable + 1 : DEB - 1) : 0;
        m_prev = f;
        m_ev = (m_stable == DEB - 1) && (f != m_km);
        if (m_ev) begin
            rise = f & ~m_km;
            fall = m_km & ~f;
            m_pr = rise != 16'h0;
            m_code = 4'(lowest(m_pr ? rise : fall));
            m_km = f;
        end
    endtask

    task automatic run_frame(input logic [15:0] mask);
        int bad;
        int q;
        logic [3:0] er;
        logic [1:0] ec;
        bad = 0;
        held = mask;
        for (int p = 1; p <= 65; p++) begin
            @(posedge clk);
            #1;
            q = p % 65;
            er = (q < 64) ? ~(4'b1 << (q / 16)) : 4'hF;
            ec = (q < 64) ? 2'(q / 16) : 2'd0;
            if (row_out !== er || count !== ec || (p < 65 && key_event !== 1'b0)) bad++;
        end
        check("scan_timing", bad, 0);
        model_eval(mask);
        check("model_km", key_matrix, m_km);
        check("model_event", key_event, m_ev);
        check("model_code", key_code, m_code);
        check("model_pressed", key_pressed, m_pr);
    endtask

    task automatic add(input logic [15:0] mask, input logic [15:0] km, input logic ev,
                       input logic [3:0] code, input logic pr);
        vec_t v;
        v.mask = mask; v.km = km; v.ev = ev; v.code = code; v.pr = pr;
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] mask;
        for (int i = 0; i < 2; i++) add(16'h0000, 16'h0000, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(16'h0200, 16'h0000, 0, 0, 0);
        add(16'h0200, 16'h0200, 1, 9, 1);
        for (int i = 0; i < 3; i++) add(16'h0000, 16'h0200, 0, 9, 1);
        add(16'h0000, 16'h0000, 1, 9, 0);
        for (int i = 0; i < 3; i++) add(16'h8001, 16'h0000, 0, 9, 0);
        add(16'h8001, 16'h8001, 1, 0, 1);
        for (int i = 0; i < 3; i++) add(16'h0000, 16'h8001, 0, 0, 1);
        add(16'h0000, 16'h0000, 1, 0, 0);
        for (int i = 0; i < 2; i++) add(16'h0020, 16'h0000, 0, 0, 0);
        add(16'h0000, 16'h0000, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(16'h0020, 16'h0000, 0, 0, 0);
        add(16'h0020, 16'h0020, 1, 5, 1);

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {row_out, count, key_matrix, key_event, key_code, key_pressed},
              {4'hF, 2'd0, 16'h0, 1'b0, 4'h0, 1'b0});
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_frame(vecs[i].mask);
            check($sformatf("vec%0d_km", i), key_matrix, vecs[i].km);
            check($sformatf("vec%0d_event", i), key_event, vecs[i].ev);
            check($sformatf("vec%0d_code", i), key_code, vecs[i].code);
            check($sformatf("vec%0d_pressed", i), key_pressed, vecs[i].pr);
        end

        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midscan_reset", {row_out, count, key_matrix, key_event, key_code, key_pressed},
              {4'hF, 2'd0, 16'h0, 1'b0, 4'h0, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check("release_row", row_out, 4'hF);
        for (int i = 0; i < 4; i++) begin
            run_frame(16'h0020);
            check("rereport_km", key_matrix, (i == 3) ? 16'h0020 : 16'h0000);
            check("rereport_event", key_event, i == 3);
            check("rereport_code", key_code, (i == 3) ? 4'd5 : 4'd0);
        end

        mask = 16'h0020;
        for (int f = 0; f < 60; f++) begin
            case ($urandom_range(0, 7))
                0: mask = (16'h1 << $urandom_range(0, 15)) |
                          (($urandom_range(0, 1) == 1) ? (16'h1 << $urandom_range(0, 15)) : 16'h0);
                1: mask = 16'h0;
                default: mask = mask;
            endcase
            run_frame(mask);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/key_matrix_scan.md
Name: key_matrix_scan

Overview:
- Reader side of the row/column matrix interface: drives one active-low row at a time, samples the active-low column returns, and builds a debounced PIXEL-bit key image.
- Emits a one-cycle event for each accepted change.
- Sits between the external button/keypad matrix and the game control logic.
- Bit mapping matches the display matrix: bit r*COL+c is row r, column c.

Parameters:
- ROW, 4, number of driven rows.
- COL, 4, number of sensed columns.
- PIXEL, ROW*COL, width of the key image.
- BIT_COUNT, 2, width of the row index (log2 ROW).
- KEY_BITS, 4, width of the key code (log2 PIXEL).
- SETTLE_CYCLES, 16, clocks each row is driven; must be >= 4.
- DEBOUNCE, 4, identical consecutive frames required to accept an image; must be >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- col_in  in  COL  column returns, active-low (0 = key closed on the driven row); asynchronous to clk.
- row_out  out  ROW  row drive, active-low, at most one bit low.
- count  out  BIT_COUNT  index of the row currently driven.
- key_matrix  out  PIXEL  debounced image, 1 = pressed.
- key_event  out  1  one-cycle pulse when key_matrix changes.
- key_code  out  KEY_BITS  index of the key reported with key_event.
- key_pressed  out  1  qualifies key_code: 1 = press, 0 = release.

Behaviour:
- Reset (async assert, sync release): all flops clear.
  - row_out = all ones; count = 0.
  - key_matrix, key_event, key_code, key_pressed = 0.
  - Internal frame, prev_frame and stable counter = 0; state = DRIVE.
- col_in passes through a 2-flop synchronizer and is inverted: pressed = 1.
- FSM states:
  - DRIVE: row_out bit[count] = 0, other bits = 1. The dwell counter runs 0..SETTLE_CYCLES-1. When dwell = SETTLE_CYCLES-1, the synchronized columns are written into frame bits [count*COL +: COL] and dwell clears. If count < ROW-1, count increments and the state stays DRIVE. If count = ROW-1, count wraps to 0 and the state goes to EVAL.
  - EVAL: lasts one cycle with row_out = all ones and count = 0. Returns to DRIVE.
  - Frame period = ROW*SETTLE_CYCLES+1 cycles (65 with defaults).
- Debounce, evaluated in the EVAL cycle:
  - If frame == prev_frame, stable = min(stable+1, DEBOUNCE-1); otherwise stable = 0.
  - prev_frame <= frame.
  - If the new stable == DEBOUNCE-1 and frame != key_matrix, then key_matrix <= frame and key_event pulses. key_matrix and key_event are visible the cycle after EVAL.
- Event code:
  - If any newly pressed bit exists (frame & ~key_matrix), key_code = lowest such index and key_pressed = 1.
  - Otherwise key_code = lowest newly released index and key_pressed = 0.
  - Multiple simultaneous changes are reported as one event. The full change is visible only in key_matrix.
- key_event lasts exactly one cycle. key_code and key_pressed hold their last value until the next event.
- A glitch shorter than one frame breaks stability. No event occurs until DEBOUNCE identical frames are seen again.
- rst_n asserted mid-scan clears the state immediately. The scan restarts at row 0 with no partial frame evaluated.
- A key held from reset is reported at the EVAL of frame DEBOUNCE. The first frame mismatches the cleared prev_frame, so the key is accepted at frame 4.

Decomposition:
- Shared package (matrix_pkg):
  - default ROW, COL and derived PIXEL, BIT_COUNT, KEY_BITS constants;
  - pixel-index function r*COL+c, shared with the display driver;
  - state enum {DRIVE, EVAL}.
- One sub-module, key_debounce: holds prev_frame, the stable counter, the key_matrix register and the event/code generation. It takes frame plus an eval strobe as inputs. The scan FSM, dwell counter and synchronizer stay in the top level.

Test Plan:
- Reset then idle, col_in = 4'b1111 (SETTLE_CYCLES=16, DEBOUNCE=4):
  - row_out cycles 1110, 1101, 1011, 0111, 16 cycles each;
  - row_out = 1111 for 1 cycle every 65;
  - count tracks the driven row; key_event never asserts.
- Key at row 2, col 1 (col_in bit1 = 0 only while row_out = 1011):
  - key_event one cycle after the 4th EVAL;
  - key_matrix = 16'h0200, key_code = 9, key_pressed = 1.
- Release the same key:
  - after 4 clean frames, key_matrix = 0 with a key_event pulse;
  - key_code = 9, key_pressed = 0.
- Press keys 0 and 15 in the same frame:
  - one key_event; key_matrix = 16'h8001, key_code = 0, key_pressed = 1.
- Bounce: hold key 5 for 2 frames, open 1 frame, hold again:
  - no event until 4 consecutive held frames;
  - then key_matrix = 16'h0020.
- Assert rst_n low mid-frame while a key is accepted:
  - all outputs are 0 immediately;
  - after release, row_out = 1110 and the key is re-reported after 4 frames.
